// File: rtl/face_coords_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : face_coords_tx_pkg
// Description : Shared frame-format definitions for the face-coordinate UART
//               transmitter: sync byte, frame length, detection record type,
//               frame-FSM state encodings and the frame byte selector. Sits
//               alongside the vj_weights.vh definitions of the detector.
//               Optional feature macro: FACE_TX_CHECKSUM_EN (7-byte frames
//               with an XOR checksum byte; 6-byte frames otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
package face_coords_tx_pkg;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

`ifdef FACE_TX_CHECKSUM_EN
    localparam int unsigned C_FRAME_LEN = 7;
`else
    localparam int unsigned C_FRAME_LEN = 6;
`endif

    localparam logic [2:0] C_LAST_BYTE_IDX = 3'(C_FRAME_LEN - 1);

    // One buffered detection: only the low 16 bits of row/col are kept.
    typedef struct packed {
        logic [3:0]  pyramid;
        logic [15:0] row;
        logic [15:0] col;
    } det_rec_t;

    // Frame FSM state encodings
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_SEND = 1'b1;

`ifdef FACE_TX_CHECKSUM_EN
    // XOR of every payload byte (everything after the sync byte).
    function automatic logic [7:0] frame_checksum(input det_rec_t rec);
        return {4'h0, rec.pyramid} ^ rec.row[7:0] ^ rec.row[15:8]
             ^ rec.col[7:0] ^ rec.col[15:8];
    endfunction
`endif

    // Byte at position idx of the frame carrying rec.
    function automatic logic [7:0] frame_byte(input det_rec_t rec, input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = C_SYNC_BYTE;
            3'd1:    v = {4'h0, rec.pyramid};
            3'd2:    v = rec.row[7:0];
            3'd3:    v = rec.row[15:8];
            3'd4:    v = rec.col[7:0];
            3'd5:    v = rec.col[15:8];
`ifdef FACE_TX_CHECKSUM_EN
            3'd6:    v = frame_checksum(rec);
`endif
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/face_coords_tx_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 UART byte serialiser, LSB first, idle high.
//               start  : load data and begin the start bit next cycle
//               data   : byte to send (sampled when start=1)
//               done   : high during the final cycle of the stop bit; a start
//                        in that same cycle chains the next byte with no gap
//               serial : registered serial line output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       serial
);

    localparam int              CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       C_STOP_BIT = 4'd9;

    // r_shift[0] is the bit to drive when the current bit period ends;
    // the top bit is the stop bit and ones are shifted in behind it.
    logic [8:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic             r_active;
    logic             r_serial;
    logic             w_bit_end;

    assign w_bit_end = r_active && (r_cnt == C_CNT_LAST);
    assign done      = w_bit_end && (r_bit == C_STOP_BIT);
    assign serial    = r_serial;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_active <= 1'b0;
            r_serial <= 1'b1;
        end else if (start) begin
            r_shift  <= {1'b1, data};
            r_cnt    <= '0;
            r_bit    <= '0;
            r_active <= 1'b1;
            r_serial <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == C_STOP_BIT) begin
                    r_active <= 1'b0;
                    r_serial <= 1'b1;
                end else begin
                    r_bit    <= r_bit + 4'd1;
                    r_serial <= r_shift[0];
                    r_shift  <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/face_coords_tx.sv
`default_nettype none
// ============================================================================
// Module      : face_coords_tx
// Description : Buffers face-detection records in a FIFO and streams each one
//               to the host as a UART frame: A5, pyramid, row lo/hi,
//               col lo/hi [, checksum]. Frames are sent back-to-back while
//               records are pending.
//               Macro FACE_TX_CHECKSUM_EN adds the 7th XOR checksum byte.
// Ports       : clock, reset_n (async, active-low)
//               face_coords[0]=row, [1]=col, pyramid_number, face_coords_ready
//               uart_tx, tx_busy, fifo_full, drop_count (saturating at 255)
// Revision    : 1.0 - initial release
// ============================================================================
module face_coords_tx
    import face_coords_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0][31:0] face_coords,
    input  logic             face_coords_ready,
    input  logic [3:0]       pyramid_number,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             fifo_full,
    output logic [7:0]       drop_count
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    det_rec_t         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [0:0]       r_state;
    logic [2:0]       r_byte_idx;
    det_rec_t         r_rec;
    logic [7:0]       r_drop;

    det_rec_t         w_rec_in;
    logic             w_full;
    logic             w_empty;
    logic             w_byte_done;
    logic             w_last_byte;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_next_byte;
    logic             w_start;
    logic [7:0]       w_tx_data;
    logic             w_unused_hi;

    // Upper coordinate bits are deliberately discarded.
    assign w_unused_hi = ^{face_coords[0][31:16], face_coords[1][31:16]};
    assign w_rec_in    = {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};

    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_last_byte = (r_byte_idx == C_LAST_BYTE_IDX);

    // Pop either from IDLE or on the very edge the last stop bit ends, so
    // consecutive frames abut with no idle bit time between them.
    assign w_pop       = !w_empty && ((r_state == C_ST_IDLE) ||
                                      (w_byte_done && w_last_byte));
    assign w_next_byte = (r_state == C_ST_SEND) && w_byte_done && !w_last_byte;
    // A pop frees a slot this cycle, so a full FIFO can still accept.
    assign w_push      = face_coords_ready && (!w_full || w_pop);
    assign w_drop      = face_coords_ready && w_full && !w_pop;

    assign w_start     = w_pop || w_next_byte;
    assign w_tx_data   = w_pop ? C_SYNC_BYTE : frame_byte(r_rec, r_byte_idx + 3'd1);

    assign tx_busy     = (r_state == C_ST_SEND);
    assign fifo_full   = w_full;
    assign drop_count  = r_drop;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (w_start),
        .data    (w_tx_data),
        .done    (w_byte_done),
        .serial  (uart_tx)
    );

    // FIFO storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_rec_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    // Frame FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= C_ST_IDLE;
            r_byte_idx <= '0;
            r_rec      <= '0;
        end else if (w_pop) begin
            r_rec      <= r_mem[r_rptr];
            r_state    <= C_ST_SEND;
            r_byte_idx <= '0;
        end else if (w_next_byte) begin
            r_byte_idx <= r_byte_idx + 3'd1;
        end else if ((r_state == C_ST_SEND) && w_byte_done) begin
            r_state    <= C_ST_IDLE;
            r_byte_idx <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_face_coords_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_face_coords_tx
// Description : Self-checking bench for face_coords_tx (CLKS_PER_BIT=4,
//               FIFO_DEPTH=8). A UART receiver decodes uart_tx; decoded bytes
//               are compared with frames built from the detection records.
//               Frame length follows FACE_TX_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_face_coords_tx;

    localparam int CPB       = 4;
    localparam int DEPTH     = 8;
`ifdef FACE_TX_CHECKSUM_EN
    localparam int LEN       = 7;
`else
    localparam int LEN       = 6;
`endif
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = LEN * BYTE_CYC;

    typedef struct {
        logic [31:0] row;
        logic [31:0] col;
        logic [3:0]  pyr;
    } det_t;

    typedef struct {
        det_t             d;
        logic [6:0][7:0]  exp;   // [0] is the first byte on the wire
    } vec_t;

    typedef struct {
        logic [7:0] b;
        bit         ok;
        int         start;
    } rx_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0][31:0] face_coords = '0;
    logic             face_coords_ready = 1'b0;
    logic [3:0]       pyramid_number = '0;
    logic             uart_tx;
    logic             tx_busy;
    logic             fifo_full;
    logic [7:0]       drop_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_total = 0;
    int   low_total = 0;
    int   epoch = 0;
    rx_t  rx_q[$];
    logic [7:0] exp_q[$];

    face_coords_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .face_coords       (face_coords),
        .face_coords_ready (face_coords_ready),
        .pyramid_number    (pyramid_number),
        .uart_tx           (uart_tx),
        .tx_busy           (tx_busy),
        .fifo_full         (fifo_full),
        .drop_count        (drop_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (tx_busy === 1'b1) busy_total <= busy_total + 1;
        if (uart_tx === 1'b0) low_total <= low_total + 1;
    end

    always @(negedge reset_n) epoch <= epoch + 1;

    // UART receiver: samples each bit in its middle, drops bytes cut by reset
    initial begin : decoder
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && uart_tx === 1'b0) begin
                automatic int         sc = cyc;
                automatic int         ep = epoch;
                automatic logic [7:0] d  = '0;
                automatic bit         ok;
                repeat (CPB / 2) @(negedge clock);
                ok = (uart_tx === 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clock);
                    d[k] = uart_tx;
                end
                repeat (CPB) @(negedge clock);
                ok = ok && (uart_tx === 1'b1);
                repeat (CPB - 1 - CPB / 2) @(negedge clock);
                if (ep == epoch) rx_q.push_back('{d, ok, sc});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference frame straight from the frame format
    function automatic logic [6:0][7:0] model_frame(input det_t d);
        logic [6:0][7:0] f;
        logic [7:0]      x;
        f    = '0;
        f[0] = 8'hA5;
        f[1] = {4'h0, d.pyr};
        f[2] = d.row[7:0];
        f[3] = d.row[15:8];
        f[4] = d.col[7:0];
        f[5] = d.col[15:8];
        x    = 8'h00;
        for (int i = 1; i <= 5; i++) x = x ^ f[i];
        f[6] = x;
        return f;
    endfunction

    function automatic det_t rand_det();
        det_t d;
        d.row = $urandom;
        d.col = $urandom;
        d.pyr = 4'($urandom_range(0, 15));
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input det_t d);
        face_coords[0]    = d.row;
        face_coords[1]    = d.col;
        pyramid_number    = d.pyr;
        face_coords_ready = 1'b1;
        tick();
        face_coords_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic expect_frame(input logic [6:0][7:0] f);
        for (int i = 0; i < LEN; i++) exp_q.push_back(f[i]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 60 && n < budget) begin
            tick();
            n++;
            quiet = (tx_busy === 1'b1) ? 0 : quiet + 1;
        end
        if (n >= budget) chk({name, " drain timeout"}, 32'(n), 32'(budget - 1));
    endtask

    task automatic check_stream(input string name, input int base);
        int n;
        n = rx_q.size() - base;
        chk({name, " byte count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk($sformatf("%s byte %0d", name, i),
                {23'd0, rx_q[base + i].ok, rx_q[base + i].b},
                {23'd0, 1'b1, exp_q[i]});
        end
        exp_q.delete();
    endtask

    initial begin : main
        vec_t tbl[3];
        det_t recs[11];
        int   base;
        int   b0;
        int   pc;
        int   gaps;

        tbl[0].d = '{32'd5, 32'd10, 4'd3};
        tbl[0].exp = {8'h0C, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h03, 8'hA5};
        tbl[1].d = '{32'hDEAD1234, 32'hBEEF00FF, 4'hF};
        tbl[1].exp = {8'hD6, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h0F, 8'hA5};
        tbl[2].d = '{32'h0000ABCD, 32'h00017F80, 4'h0};
        tbl[2].exp = {8'h99, 8'h7F, 8'h80, 8'hAB, 8'hCD, 8'h00, 8'hA5};

        // Reset state
        repeat (3) tick();
        chk("reset uart_tx", 32'(uart_tx), 32'd1);
        chk("reset tx_busy", 32'(tx_busy), 32'd0);
        chk("reset fifo_full", 32'(fifo_full), 32'd0);
        chk("reset drop_count", 32'(drop_count), 32'd0);
        reset_n = 1'b1;
        repeat (5) tick();
        chk("idle line after reset", 32'(low_total), 32'd0);

        // Single frames from the vector table
        for (int v = 0; v < 3; v++) begin
            base = rx_q.size();
            b0   = busy_total;
            pc   = cyc;
            pulse(tbl[v].d);
            wait_idle($sformatf("vec%0d", v), 5000);
            expect_frame(tbl[v].exp);
            if (rx_q.size() > base)
                chk($sformatf("vec%0d start latency", v), 32'(rx_q[base].start), 32'(pc + 2));
            chk($sformatf("vec%0d busy cycles", v), 32'(busy_total - b0), 32'(FRAME_CYC));
            check_stream($sformatf("vec%0d", v), base);
        end

        // Ten back-to-back pulses, then a pulse on the pop cycle while full
        do_reset();
        for (int i = 0; i < 11; i++) recs[i] = rand_det();
        base = rx_q.size();
        b0   = busy_total;
        pc   = cyc;
        for (int i = 0; i < 10; i++) pulse(recs[i]);
        chk("burst drop_count", 32'(drop_count), 32'd1);
        chk("burst fifo_full", 32'(fifo_full), 32'd1);
        while (cyc < pc + 1 + FRAME_CYC) tick();
        chk("full before pop", 32'(fifo_full), 32'd1);
        pulse(recs[10]);
        chk("full after pop+push", 32'(fifo_full), 32'd1);
        chk("drop_count after pop+push", 32'(drop_count), 32'd1);
        wait_idle("burst", 20000);
        for (int i = 0; i < 9; i++) expect_frame(model_frame(recs[i]));
        expect_frame(model_frame(recs[10]));
        if (rx_q.size() > base) begin
            gaps = 0;
            chk("burst start latency", 32'(rx_q[base].start), 32'(pc + 2));
            for (int i = base; i < rx_q.size(); i++)
                if (rx_q[i].start != rx_q[base].start + BYTE_CYC * (i - base)) gaps++;
            chk("burst contiguous bytes", 32'(gaps), 32'd0);
        end
        chk("burst busy cycles", 32'(busy_total - b0), 32'(10 * FRAME_CYC));
        check_stream("burst", base);

        // Reset during the third byte abandons the frame
        do_reset();
        base = rx_q.size();
        pc   = cyc;
        pulse(tbl[0].d);
        while (cyc < pc + 2 + 2 * BYTE_CYC + 15) tick();
        chk("line low mid third byte", 32'(low_total > 0), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset uart_tx", 32'(uart_tx), 32'd1);
        chk("async reset tx_busy", 32'(tx_busy), 32'd0);
        chk("bytes before reset", 32'(rx_q.size() - base), 32'd2);
        tick();
        tick();
        reset_n = 1'b1;
        base = rx_q.size();
        b0   = low_total;
        repeat (400) tick();
        chk("no resume after reset", 32'(rx_q.size() - base), 32'd0);
        chk("line idle after reset", 32'(low_total - b0), 32'd0);
        chk("busy idle after reset", 32'(tx_busy), 32'd0);
        pulse(tbl[1].d);
        wait_idle("post-reset", 5000);
        expect_frame(tbl[1].exp);
        check_stream("post-reset", base);

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 100; i++) pulse(rand_det());
        chk("drop_count after 100", 32'(drop_count), 32'd91);
        for (int i = 0; i < 200; i++) pulse(rand_det());
        chk("drop_count saturated", 32'(drop_count), 32'd255);
        chk("full while flooding", 32'(fifo_full), 32'd1);
        wait_idle("flood", 20000);
        chk("drop_count held", 32'(drop_count), 32'd255);
        chk("fifo drained", 32'(fifo_full), 32'd0);

        // Randomised bursts with random spacing, never overflowing
        do_reset();
        for (int r = 0; r < 3; r++) begin
            int   n;
            det_t d;
            base = rx_q.size();
            n    = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                d = rand_det();
                expect_frame(model_frame(d));
                pulse(d);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_idle($sformatf("rand%0d", r), 20000);
            check_stream($sformatf("rand%0d", r), base);
            chk($sformatf("rand%0d drop_count", r), 32'(drop_count), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
